// File: rtl/ysyx_24100005_pkg.sv
// ysyx_24100005_pkg
//   Constants shared by the ysyx_24100005 RV32 core: the architectural data
//   width, the register-address width, the PC reset vector and the index of
//   the hardwired zero register.
package ysyx_24100005_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  localparam int unsigned     REG_ZERO = 0;

endpackage : ysyx_24100005_pkg

// File: rtl/ysyx_24100005_reg_cell.sv
// ysyx_24100005_reg_cell
//   Generic resettable register. Used for every register-file entry and,
//   standalone, as the PC register (RESET_VAL = RESET_PC, wen tied high).
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset, dominates wen
//   din   in   [WIDTH] data to load
//   wen   in   load enable
//   dout  out  [WIDTH] registered value (never combinational from din)
module ysyx_24100005_reg_cell
  import ysyx_24100005_pkg::*;
#(
  parameter int unsigned      WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] val_d;

  // Next-value select: reset first, then load, else hold.
  always_comb begin
    val_d = val_q;
    if (rst) begin
      val_d = RESET_VAL;
    end else if (wen) begin
      val_d = din;
    end
  end

  always_ff @(posedge clk) begin
    val_q <= val_d;
  end

  assign dout = val_q;

endmodule : ysyx_24100005_reg_cell

// File: rtl/ysyx_24100005_reg_file.sv
// ysyx_24100005_reg_file
//   General-purpose register file: 2^ADDR_WIDTH entries of DATA_WIDTH bits,
//   one combinational read port, one synchronous write port. Entry 0 is a
//   constant zero with no storage behind it.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset, clears all entries, beats wen
//   wen    in   write enable
//   waddr  in   [ADDR_WIDTH] write address (writes to 0 are dropped)
//   wdata  in   [DATA_WIDTH] write data
//   raddr  in   [ADDR_WIDTH] read address
//   rdata  out  [DATA_WIDTH] read data, combinational, no write bypass
module ysyx_24100005_reg_file
  import ysyx_24100005_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
  parameter int unsigned DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned NUM_ENTRIES = 1 << ADDR_WIDTH;

  logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0] entry_q;
  logic [NUM_ENTRIES-1:0]                 cell_wen;

  // Entry 0 has no cell; it is a constant so writes to it vanish.
  assign entry_q[REG_ZERO] = '0;
  assign cell_wen[REG_ZERO] = 1'b0;

  // One storage cell per architectural register x1..x(N-1).
  for (genvar i = 1; i < NUM_ENTRIES; i++) begin : g_entry
    assign cell_wen[i] = wen && (waddr == ADDR_WIDTH'(i));

    ysyx_24100005_reg_cell #(
      .WIDTH     (DATA_WIDTH),
      .RESET_VAL ('0)
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .din  (wdata),
      .wen  (cell_wen[i]),
      .dout (entry_q[i])
    );
  end

  // Plain read select from stored values only; a same-address write shows
  // up after the edge, which keeps rdata->wdata loops in the core stable.
  always_comb begin
    rdata = entry_q[raddr];
  end

endmodule : ysyx_24100005_reg_file

// File: tb/tb_ysyx_24100005_reg_file.sv
module tb_ysyx_24100005_reg_file;

  logic        clk;
  logic        rst;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;

  logic [31:0] wdata_tb;
  logic        loop_mode;

  logic        pc_rst;
  logic        pc_wen;
  logic [31:0] pc_din;
  logic [31:0] pc_dout;

  int pass_cnt;
  int total_cnt;

  ysyx_24100005_reg_file #(
    .ADDR_WIDTH (5),
    .DATA_WIDTH (32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .wen   (wen),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  ysyx_24100005_reg_cell #(
    .WIDTH     (32),
    .RESET_VAL (32'h8000_0000)
  ) u_pc (
    .clk  (clk),
    .rst  (pc_rst),
    .din  (pc_din),
    .wen  (pc_wen),
    .dout (pc_dout)
  );

  // Loop mode models the core's rdata -> adder -> wdata path.
  assign wdata  = loop_mode ? (rdata + 32'h0000_07FF) : wdata_tb;
  assign pc_din = pc_dout + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wen      = 1'b1;
    waddr    = a;
    wdata_tb = d;
    tick();
    wen      = 1'b0;
  endtask

  task automatic test_reset();
    wr(5'd7, 32'hDEAD_BEEF);
    raddr = 5'd7;
    #1;
    total_cnt++;
    if (rdata !== 32'hDEAD_BEEF)
      $display("FAIL pre_reset_x7 got %h want %h", rdata, 32'hDEAD_BEEF);
    else pass_cnt++;
    rst      = 1'b1;
    wen      = 1'b1;
    waddr    = 5'd3;
    wdata_tb = 32'd5;
    tick();
    rst = 1'b0;
    wen = 1'b0;
    for (int i = 1; i < 32; i++) begin
      raddr = 5'(i);
      #1;
      total_cnt++;
      if (rdata !== 32'h0)
        $display("FAIL reset_clear x%0d got %h want %h", i, rdata, 32'h0);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_release();
    rst      = 1'b1;
    wen      = 1'b1;
    waddr    = 5'd9;
    wdata_tb = 32'h1234_5678;
    tick();
    tick();
    raddr = 5'd9;
    #1;
    total_cnt++;
    if (rdata !== 32'h0)
      $display("FAIL reset_hold_x9 got %h want %h", rdata, 32'h0);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    wen = 1'b0;
    total_cnt++;
    if (rdata !== 32'h1234_5678)
      $display("FAIL first_write_after_rst got %h want %h", rdata, 32'h1234_5678);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    raddr = 5'd5;
    wen      = 1'b1;
    waddr    = 5'd5;
    wdata_tb = 32'h0000_0123;
    #1;
    total_cnt++;
    if (rdata !== 32'h0)
      $display("FAIL x5_before_edge got %h want %h", rdata, 32'h0);
    else pass_cnt++;
    tick();
    wen = 1'b0;
    total_cnt++;
    if (rdata !== 32'h0000_0123)
      $display("FAIL x5_write got %h want %h", rdata, 32'h0000_0123);
    else pass_cnt++;
    wr(5'd0, 32'hFFFF_FFFF);
    raddr = 5'd0;
    #1;
    total_cnt++;
    if (rdata !== 32'h0)
      $display("FAIL x0_zero got %h want %h", rdata, 32'h0);
    else pass_cnt++;
  endtask

  task automatic test_wen();
    wr(5'd6, 32'h1111_1111);
    wen      = 1'b0;
    waddr    = 5'd6;
    wdata_tb = 32'hAAAA_5555;
    tick();
    raddr = 5'd6;
    #1;
    total_cnt++;
    if (rdata !== 32'h1111_1111)
      $display("FAIL wen_low_x6 got %h want %h", rdata, 32'h1111_1111);
    else pass_cnt++;
  endtask

  task automatic test_rdw_loop();
    wr(5'd5, 32'h0000_0001);
    raddr     = 5'd5;
    waddr     = 5'd5;
    wen       = 1'b1;
    loop_mode = 1'b1;
    #1;
    total_cnt++;
    if (rdata !== 32'h0000_0001)
      $display("FAIL loop_before_edge got %h want %h", rdata, 32'h0000_0001);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rdata !== 32'h0000_0800)
      $display("FAIL loop_edge1 got %h want %h", rdata, 32'h0000_0800);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (rdata !== 32'h0000_0FFF)
      $display("FAIL loop_edge2 got %h want %h", rdata, 32'h0000_0FFF);
    else pass_cnt++;
    wen       = 1'b0;
    loop_mode = 1'b0;
  endtask

  task automatic test_sweep();
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'(i) * 32'h0101_0101);
    end
    for (int i = 1; i < 32; i++) begin
      raddr = 5'(i);
      #1;
      total_cnt++;
      if (rdata !== 32'(i) * 32'h0101_0101)
        $display("FAIL sweep x%0d got %h want %h", i, rdata, 32'(i) * 32'h0101_0101);
      else pass_cnt++;
    end
  endtask

  task automatic test_pc();
    logic [31:0] exp_pc;
    pc_wen = 1'b1;
    pc_rst = 1'b1;
    tick();
    pc_rst = 1'b0;
    total_cnt++;
    if (pc_dout !== 32'h8000_0000)
      $display("FAIL pc_reset got %h want %h", pc_dout, 32'h8000_0000);
    else pass_cnt++;
    exp_pc = 32'h8000_0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_pc = exp_pc + 32'd4;
      total_cnt++;
      if (pc_dout !== exp_pc)
        $display("FAIL pc_step%0d got %h want %h", k, pc_dout, exp_pc);
      else pass_cnt++;
    end
    pc_rst = 1'b1;
    tick();
    pc_rst = 1'b0;
    total_cnt++;
    if (pc_dout !== 32'h8000_0000)
      $display("FAIL pc_midrun_reset got %h want %h", pc_dout, 32'h8000_0000);
    else pass_cnt++;
    tick();
    pc_wen = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (pc_dout !== 32'h8000_0004)
      $display("FAIL pc_hold got %h want %h", pc_dout, 32'h8000_0004);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    wen       = 1'b0;
    waddr     = 5'd0;
    wdata_tb  = 32'h0;
    raddr     = 5'd0;
    loop_mode = 1'b0;
    pc_rst    = 1'b1;
    pc_wen    = 1'b0;
    tick();
    rst = 1'b0;
    test_reset();
    test_reset_release();
    test_write_read();
    test_wen();
    test_rdw_loop();
    test_sweep();
    test_pc();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_ysyx_24100005_reg_file

// File: doc/ysyx_24100005_reg_file.md
# ysyx_24100005_reg_file

General-purpose register file for the ysyx_24100005 single-cycle RV32 core. It provides 2^ADDR_WIDTH entries of DATA_WIDTH bits, with one asynchronous read port and one synchronous write port. Entry 0 is hardwired to zero. Each storage entry is an instance of the generic resettable register cell, and the core also instantiates that cell standalone as the PC register.

## Interface
Parameters:
- ADDR_WIDTH, default 5: address width; the file holds 2^ADDR_WIDTH entries.
- DATA_WIDTH, default 32: width of each entry.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset; clears every entry.
- wen  input  1  write enable.
- waddr  input  ADDR_WIDTH  write address.
- wdata  input  DATA_WIDTH  write data.
- raddr  input  ADDR_WIDTH  read address.
- rdata  output  DATA_WIDTH  read data (combinational).

## Operation
- Read:
  - rdata = entry[raddr], purely combinational from current storage.
  - rdata = 0 whenever raddr = 0.
- Write: at a rising clk edge with rst=0, wen=1 and waddr≠0, entry[waddr] ← wdata.
- Write to address 0: silently discarded; entry 0 always reads 0.
- wen=0: no entry changes.
- Reset:
  - At a rising clk edge with rst=1, every entry becomes 0.
  - Reset dominates wen; no write occurs that cycle.
  - rdata reflects the cleared contents immediately after that edge.
- Read-during-write to the same address:
  - rdata shows the old value until the edge, then the new value.
  - There is no write-to-read bypass.
  - This allows the core's combinational loop rdata → adder → wdata with waddr = raddr (e.g. addi x5,x5,imm) to settle without oscillation.
- All writes are full width; there are no byte enables and no sign or width conversion.
- Contents before the first reset are undefined. The core must assert rst for at least one edge before relying on reads.

## Timing
- Read latency: 0 cycles (combinational path from raddr and storage to rdata).
- Write latency: 1 edge. A value written at edge N is visible on rdata right after edge N when raddr matches.
- One write per cycle maximum.
- Reset takes effect at the first rising edge where rst=1 and holds while rst stays high.
- Deasserting rst mid-operation: the first write is accepted at the first edge with rst=0.
- Boundary addresses:
  - waddr = 2^ADDR_WIDTH−1 (x31) writes normally.
  - Addresses never wrap or alias.

## Structure
- Shared package ysyx_24100005_pkg holds:
  - constants XLEN=32 and REG_ADDR_W=5
  - RESET_PC=32'h8000_0000
  - REG_ZERO=0
- Sub-module ysyx_24100005_reg_cell, a generic register:
  - Parameters: WIDTH (default 32) and RESET_VAL (default 0).
  - Ports: clk, rst, din[WIDTH], wen, dout[WIDTH].
  - On a rising edge: dout ← RESET_VAL if rst; else dout ← din if wen; else hold.
  - Reset dominates wen.
  - dout is the registered output and is never combinational from din.
- Generate one reg_cell per entry 1..2^ADDR_WIDTH−1 with RESET_VAL=0 and per-cell wen = wen & (waddr==i).
- Entry 0 is a constant zero and has no cell.
- The read mux is a plain combinational select over the cell outputs.
- The core reuses reg_cell with WIDTH=32 and RESET_VAL=RESET_PC as the PC register, with wen tied high and din = PC+4.

## Test plan
- Reset clear: write 0xDEADBEEF to x7, then assert rst for 1 edge → rdata=0 for raddr=1..31. During the rst edge, wen=1, waddr=3, wdata=5 → x3 still reads 0.
- Write/read and x0: wen=1, waddr=5, wdata=0x0000_0123, raddr=5 → rdata=0x0000_0123 after the edge. Write 0xFFFF_FFFF to x0 → raddr=0 returns 0.
- Write enable: wen=0, waddr=6, wdata=0xAAAA_5555 → x6 keeps its previous value.
- Read-during-write loop:
  - Setup: x5=1; drive wdata = rdata + 0x7FF combinationally, with raddr=waddr=5 and wen=1.
  - Before the edge: rdata=0x001.
  - After edge 1: rdata=0x800. After edge 2: rdata=0xFFF.
- Full address sweep: write the value i·0x0101_0101 to each xi for i=1..31, then read all 31 → each xi returns exactly its own value with no aliasing, including x31.
- reg_cell as PC (WIDTH=32, RESET_VAL=0x8000_0000, wen=1, din=dout+4):
  - 1 reset edge → dout=0x8000_0000.
  - Next 3 edges → 0x8000_0004, 0x8000_0008, 0x8000_000C.
  - rst=1 mid-run → 0x8000_0000 at the next edge.
  - With wen=0, dout holds.
